// File: rtl/demod_sched_pkg.sv
// Shared types and constants for the demodulator scheduler.
package demod_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } sched_state_t;

  // last_served encoding: 2'b00 / 2'b01 are channel ids, CH_NONE means nothing served yet
  localparam logic [1:0] CH_NONE   = 2'b10;
  localparam int         ANGLE_MSB = 31;
  localparam int         ANGLE_LSB = 16;
  localparam int         ANGLE_W   = ANGLE_MSB - ANGLE_LSB + 1;

  function automatic logic [1:0] ch_code(input logic ch);
    return {1'b0, ch};
  endfunction

endpackage

// File: rtl/demod_sched_if.sv
// AXI-Stream style bundle used for both slave channels and the shared master stream.
interface demod_sched_if #(
  parameter int DATA_W = 32
) ();
  localparam int STRB_W = DATA_W / 8;

  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;
  logic [STRB_W-1:0] tstrb;
  logic [1:0]        tuser;

  modport master (output tvalid, tdata, tstrb, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/demod_sched_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the channel not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // grant selection
  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = 1'b0;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = 1'b1;
      end
      2'b11: begin
        gnt    = last_grant ? 2'b01 : 2'b10;
        gnt_id = ~last_grant;
      end
      default: begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/demod_sched.sv
// Time-shares one demodulator between two angle streams, switching only at packet ends.
// DEMOD_SCHED_PRIME_EN: emit a prime beat carrying the saved angle when the served channel changes.
module demod_sched
  import demod_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
  input  logic            s00_axis_aclk,
  input  logic            s00_axis_areset,
  demod_sched_if.slave    s00_axis,
  demod_sched_if.slave    s01_axis,
  demod_sched_if.master   m00_axis,
  output logic            busy
);

  localparam int S_STRB_W = C_S00_AXIS_TDATA_WIDTH / 8;
  localparam int M_STRB_W = C_M00_AXIS_TDATA_WIDTH / 8;

  sched_state_t state_r;
  sched_state_t state_nxt_s;
  logic         gnt_ch_r;
  logic         last_grant_r;

  logic [1:0]   req_s;
  logic [1:0]   gnt_s;
  logic         gnt_id_s;

  logic         out_free_s;
  logic         s00_ready_s;
  logic         s01_ready_s;
  logic         acc_s;
  logic         prime_load_s;
  logic         busy_s;

  logic                              sel_valid_s;
  logic                              sel_last_s;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] sel_data_s;
  logic [S_STRB_W-1:0]               sel_strb_s;

  logic                              out_valid_r;
  logic                              out_last_r;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] out_data_r;
  logic [M_STRB_W-1:0]               out_strb_r;
  logic [1:0]                        out_user_r;

`ifdef DEMOD_SCHED_PRIME_EN
  logic [1:0]         last_served_r;
  logic [ANGLE_W-1:0] saved_angle_r [2];
`endif

  assign req_s = {s01_axis.tvalid, s00_axis.tvalid};

  rr_arb2 u_arb (
    .req        (req_s),
    .last_grant (last_grant_r),
    .gnt        (gnt_s),
    .gnt_id     (gnt_id_s)
  );

  assign sel_valid_s = gnt_ch_r ? s01_axis.tvalid : s00_axis.tvalid;
  assign sel_last_s  = gnt_ch_r ? s01_axis.tlast  : s00_axis.tlast;
  assign sel_data_s  = gnt_ch_r ? s01_axis.tdata  : s00_axis.tdata;
  assign sel_strb_s  = gnt_ch_r ? s01_axis.tstrb  : s00_axis.tstrb;

  // output register can take a beat when empty or draining this cycle
  assign out_free_s = m00_axis.tready || !out_valid_r;
  assign acc_s      = sel_valid_s && (gnt_ch_r ? s01_ready_s : s00_ready_s);

  // FSM state register
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (|gnt_s) begin
`ifdef DEMOD_SCHED_PRIME_EN
          state_nxt_s = (ch_code(gnt_id_s) != last_served_r) ? PRIME : STREAM;
`else
          state_nxt_s = STREAM;
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRIME:   state_nxt_s = out_free_s ? STREAM : PRIME;
      STREAM:  state_nxt_s = (acc_s && sel_last_s) ? IDLE : STREAM;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: slave readies, prime load strobe, busy
  always_comb begin
    s00_ready_s  = 1'b0;
    s01_ready_s  = 1'b0;
    prime_load_s = 1'b0;
    busy_s       = (state_r != IDLE);
    case (state_r)
      PRIME: begin
`ifdef DEMOD_SCHED_PRIME_EN
        prime_load_s = out_free_s;
`else
        prime_load_s = 1'b0;
`endif
      end
      STREAM: begin
        s00_ready_s = out_free_s && !gnt_ch_r;
        s01_ready_s = out_free_s &&  gnt_ch_r;
      end
      default: begin
        s00_ready_s = 1'b0;
        s01_ready_s = 1'b0;
      end
    endcase
  end

  // grant bookkeeping, latched when leaving IDLE
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      gnt_ch_r     <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (state_r == IDLE && (|gnt_s)) begin
      gnt_ch_r     <= gnt_id_s;
      last_grant_r <= gnt_id_s;
    end
  end

`ifdef DEMOD_SCHED_PRIME_EN
  // per-channel angle history and identity of the channel the demodulator last saw
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      last_served_r  <= CH_NONE;
      saved_angle_r[0] <= {ANGLE_W{1'b0}};
      saved_angle_r[1] <= {ANGLE_W{1'b0}};
    end else begin
      if (prime_load_s) begin
        last_served_r <= ch_code(gnt_ch_r);
      end
      if (acc_s) begin
        saved_angle_r[gnt_ch_r] <= sel_data_s[ANGLE_MSB:ANGLE_LSB];
      end
    end
  end
`endif

  // master output register; a load in the same cycle as a drain keeps tvalid high
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {C_M00_AXIS_TDATA_WIDTH{1'b0}};
      out_strb_r  <= {M_STRB_W{1'b0}};
      out_user_r  <= 2'b00;
`ifdef DEMOD_SCHED_PRIME_EN
    end else if (prime_load_s) begin
      out_valid_r <= 1'b1;
      out_last_r  <= 1'b0;
      out_data_r  <= {saved_angle_r[gnt_ch_r], {(C_M00_AXIS_TDATA_WIDTH-ANGLE_W){1'b0}}};
      out_strb_r  <= {M_STRB_W{1'b1}};
      out_user_r  <= {1'b1, gnt_ch_r};
`endif
    end else if (acc_s) begin
      out_valid_r <= 1'b1;
      out_last_r  <= sel_last_s;
      out_data_r  <= C_M00_AXIS_TDATA_WIDTH'(sel_data_s);
      out_strb_r  <= M_STRB_W'(sel_strb_s);
      out_user_r  <= {1'b0, gnt_ch_r};
    end else if (m00_axis.tready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign s00_axis.tready = s00_ready_s;
  assign s01_axis.tready = s01_ready_s;
  assign m00_axis.tvalid = out_valid_r;
  assign m00_axis.tlast  = out_last_r;
  assign m00_axis.tdata  = out_data_r;
  assign m00_axis.tstrb  = out_strb_r;
  assign m00_axis.tuser  = out_user_r;
  assign busy            = busy_s;

endmodule

// File: tb/tb_demod_sched.sv
// Scoreboard bench for demod_sched; expectations follow DEMOD_SCHED_PRIME_EN when defined.
module tb_demod_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  demod_sched_if #(.DATA_W(32)) s00_if ();
  demod_sched_if #(.DATA_W(32)) s01_if ();
  demod_sched_if #(.DATA_W(32)) m00_if ();

  demod_sched #(
    .C_S00_AXIS_TDATA_WIDTH (32),
    .C_M00_AXIS_TDATA_WIDTH (32)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis        (s00_if),
    .s01_axis        (s01_if),
    .m00_axis        (m00_if),
    .busy            (busy)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic [1:0]  user;
  } beat_t;

  beat_t exp_q [$];
  int    out_cyc_q [$];
  beat_t mon_got;
  beat_t mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pop one expectation per handshake on the master stream, and check ready gating
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ((s00_if.tready && s01_if.tready) ||
          ((s00_if.tready || s01_if.tready) && !(m00_if.tready || !m00_if.tvalid))) begin
        bad++;
        $display("FAIL tready_rule t=%0t got s00=%b s01=%b m_tvalid=%b m_tready=%b",
                 $time, s00_if.tready, s01_if.tready, m00_if.tvalid, m00_if.tready);
      end
      if (m00_if.tvalid && m00_if.tready) begin
        mon_got = '{data: m00_if.tdata, strb: m00_if.tstrb, last: m00_if.tlast, user: m00_if.tuser};
        out_cyc_q.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat got data=%h strb=%h last=%b user=%b",
                   mon_got.data, mon_got.strb, mon_got.last, mon_got.user);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            bad++;
            $display("FAIL beat got data=%h strb=%h last=%b user=%b want data=%h strb=%h last=%b user=%b",
                     mon_got.data, mon_got.strb, mon_got.last, mon_got.user,
                     mon_exp.data, mon_exp.strb, mon_exp.last, mon_exp.user);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] beat_data(input int ch, input int i, input logic [15:0] base);
    logic [15:0] ang;
    ang = base + 16'(i) * 16'h1000;
    return {ang, 8'(ch), 8'(i)};
  endfunction

  task automatic push_prime(input int ch, input logic [15:0] angle);
`ifdef DEMOD_SCHED_PRIME_EN
    exp_q.push_back('{data: {angle, 16'h0000}, strb: 4'hF, last: 1'b0, user: {1'b1, 1'(ch)}});
`else
    if (ch > 1 || angle === 16'hxxxx) $display("bad prime arguments");
`endif
  endtask

  task automatic push_pkt(input int ch, input int n, input logic [15:0] base,
                          input logic [3:0] strb, input bit with_last);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{data: beat_data(ch, i, base), strb: strb,
                        last: (with_last && i == n - 1), user: {1'b0, 1'(ch)}});
    end
  endtask

  task automatic drive(input int ch, input logic v, input logic [31:0] d,
                       input logic [3:0] s, input logic l);
    if (ch == 0) begin
      s00_if.tvalid = v; s00_if.tdata = d; s00_if.tstrb = s; s00_if.tlast = l;
    end else begin
      s01_if.tvalid = v; s01_if.tdata = d; s01_if.tstrb = s; s01_if.tlast = l;
    end
  endtask

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // called just after a rising edge; returns just after the edge that accepted the last beat
  task automatic send_pkt(input int ch, input int n, input logic [15:0] base,
                          input logic [3:0] strb, input bit with_last);
    bit hs;
    int guard;
    for (int i = 0; i < n; i++) begin
      drive(ch, 1'b1, beat_data(ch, i, base), strb, with_last && (i == n - 1));
      hs = 1'b0;
      guard = 0;
      while (!hs) begin
        @(negedge clk);
        hs = (ch == 0) ? (s00_if.tvalid && s00_if.tready) : (s01_if.tvalid && s01_if.tready);
        @(posedge clk);
        #1;
        guard++;
        if (!hs && guard > 300) begin
          total++;
          bad++;
          $display("FAIL handshake_timeout ch=%0d beat=%0d got no tready want tready within 300 cycles", ch, i);
          finish_now();
        end
      end
    end
    drive(ch, 1'b0, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [1:0] rdy_pat [8] = '{2'b1, 2'b0, 2'b0, 2'b1, 2'b0, 2'b1, 2'b1, 2'b0};

  initial begin
    s00_if.tuser = 2'b00;
    s01_if.tuser = 2'b00;
    drive(0, 1'b0, 32'h0, 4'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 4'h0, 1'b0);
    m00_if.tready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 64'(m00_if.tvalid), 64'd0);
    check("rst_tdata",  64'(m00_if.tdata),  64'd0);
    check("rst_tstrb",  64'(m00_if.tstrb),  64'd0);
    check("rst_tuser",  64'(m00_if.tuser),  64'd0);
    check("rst_treadys", 64'({s00_if.tready, s01_if.tready}), 64'd0);
    check("rst_busy",   64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single ch0 packet, first grant primes with angle 0
    push_prime(0, 16'h0000);
    push_pkt(0, 3, 16'h1000, 4'hF, 1'b1);
    fork
      send_pkt(0, 3, 16'h1000, 4'hF, 1'b1);
      begin
        @(negedge clk);
        check("busy_before_grant", 64'(busy), 64'd0);
        @(negedge clk);
        check("busy_granted", 64'(busy), 64'd1);
      end
    join
    wait_drain("drain_single");
    check("busy_idle", 64'(busy), 64'd0);

    // both channels contend: alternation with prime beats on each switch
    do_reset();
    push_prime(0, 16'h0000);
    push_pkt(0, 2, 16'h1000, 4'hF, 1'b1);
    push_prime(1, 16'h0000);
    push_pkt(1, 3, 16'h4000, 4'h3, 1'b1);
    push_prime(0, 16'h2000);
    push_pkt(0, 2, 16'h5000, 4'hC, 1'b1);
    fork
      begin
        send_pkt(0, 2, 16'h1000, 4'hF, 1'b1);
        send_pkt(0, 2, 16'h5000, 4'hC, 1'b1);
      end
      send_pkt(1, 3, 16'h4000, 4'h3, 1'b1);
    join
    wait_drain("drain_rr");

    // back-to-back ch0 packets: no re-prime, one bubble between packets
    do_reset();
    push_prime(0, 16'h0000);
    push_pkt(0, 2, 16'h1000, 4'hF, 1'b1);
    push_pkt(0, 2, 16'h7000, 4'hF, 1'b1);
    out_cyc_q.delete();
    send_pkt(0, 2, 16'h1000, 4'hF, 1'b1);
    send_pkt(0, 2, 16'h7000, 4'hF, 1'b1);
    wait_drain("drain_b2b");
`ifdef DEMOD_SCHED_PRIME_EN
    check("b2b_count", 64'(out_cyc_q.size()), 64'd5);
    if (out_cyc_q.size() == 5) check("b2b_gap", 64'(out_cyc_q[3] - out_cyc_q[2]), 64'd2);
`else
    check("b2b_count", 64'(out_cyc_q.size()), 64'd4);
    if (out_cyc_q.size() == 4) check("b2b_gap", 64'(out_cyc_q[2] - out_cyc_q[1]), 64'd2);
`endif

    // master backpressure pattern during a packet
    push_pkt(0, 4, 16'h2000, 4'hF, 1'b1);
    fork
      send_pkt(0, 4, 16'h2000, 4'hF, 1'b1);
      begin
        for (int k = 0; k < 8; k++) begin
          @(posedge clk); #1;
          m00_if.tready = rdy_pat[k][0];
        end
        @(posedge clk); #1;
        m00_if.tready = 1'b1;
      end
    join
    wait_drain("drain_bp");

    // reset mid-packet after beat 2 of 4
    push_pkt(0, 2, 16'h3000, 4'hF, 1'b0);
    send_pkt(0, 2, 16'h3000, 4'hF, 1'b0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_tvalid", 64'(m00_if.tvalid), 64'd0);
    check("arst_tdata",  64'(m00_if.tdata),  64'd0);
    check("arst_tuser",  64'(m00_if.tuser),  64'd0);
    check("arst_tready", 64'(s00_if.tready), 64'd0);
    check("arst_busy",   64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_tvalid", 64'(m00_if.tvalid), 64'd0);
    check("post_rst_queue", 64'(exp_q.size()), 64'd0);
    push_prime(0, 16'h0000);
    push_pkt(0, 1, 16'h6000, 4'hF, 1'b1);
    send_pkt(0, 1, 16'h6000, 4'hF, 1'b1);
    wait_drain("drain_post_rst");

    finish_now();
  end

endmodule

// File: doc/demod_sched.md
DEMOD_SCHED -- requirements
Module: demod_sched

Interface
REQ-001 Parameter C_S00_AXIS_TDATA_WIDTH, default 32, width of both slave streams.
REQ-002 Parameter C_M00_AXIS_TDATA_WIDTH, default 32, width of the master stream.
REQ-003 Ports:
- s00_axis_aclk  in  1  the only clock.
- s00_axis_areset  in  1  asynchronous, active-high reset.
- s00_axis_{tvalid,tlast} in 1, s00_axis_tdata in 32, s00_axis_tstrb in 4, s00_axis_tready out 1: channel 0 IQ/angle stream, angle in [31:16].
- s01_axis_{tvalid,tlast} in 1, s01_axis_tdata in 32, s01_axis_tstrb in 4, s01_axis_tready out 1: channel 1, same format.
- m00_axis_tready in 1, m00_axis_{tvalid,tlast} out 1, m00_axis_tdata out 32, m00_axis_tstrb out 4: shared stream to the demodulator.
- m00_axis_tuser  out  2  [0]=channel id, [1]=prime beat (downstream discards its result).
- busy  out  1  high while a packet is granted.

Function
REQ-004 The block SHALL time-share one demodulator between two channels, arbitrating only at packet (tlast) boundaries.
REQ-005 The FSM SHALL have states IDLE, PRIME, STREAM.
REQ-006 In IDLE with one tvalid high, that channel SHALL be granted; with both high, the channel not granted last SHALL win (round-robin); with neither high, the FSM SHALL stay in IDLE.
REQ-007 A grant from IDLE SHALL go to PRIME if the granted channel differs from last_served, else to STREAM.
REQ-008 In PRIME, both slave treadys SHALL be low; when the output register is free, one beat SHALL be loaded: tdata={saved_angle[ch],16'h0000}, tstrb=4'hF, tlast=0, tuser={1,ch}; then last_served<=ch and the FSM SHALL go to STREAM.
REQ-009 In STREAM, only the granted channel's tready SHALL be asserted, equal to m00_axis_tready || !m00_axis_tvalid; the other channel's tready SHALL be 0.
REQ-010 Each accepted beat SHALL be registered to the master with tdata, tstrb and tlast unchanged, tuser={0,ch}, and latency 1 cycle.
REQ-011 Each accepted beat SHALL update saved_angle[ch] <= tdata[31:16].
REQ-012 Acceptance of a beat with tlast=1 SHALL return the FSM to IDLE on the next cycle, giving one arbitration bubble between packets.
REQ-013 m00_axis_tvalid SHALL clear when m00_axis_tready is high and no new beat loads in that cycle; a simultaneous load and drain SHALL keep tvalid high with the new data.
REQ-014 busy SHALL be high in PRIME and STREAM and low in IDLE.
REQ-015 A channel that drops tvalid mid-packet SHALL keep the grant; there is no timeout.

Reset
REQ-016 Reset SHALL force:
- state=IDLE
- all m00_axis outputs=0
- both treadys=0
- busy=0
- saved_angle[0..1]=0
- last_grant=1, so channel 0 wins the first tie
- last_served=none, so the first grant always primes.
REQ-017 Reset asserted mid-packet SHALL discard the packet and any pending output beat, with no partial beat emitted after release.

Configuration
REQ-018 Macro DEMOD_SCHED_PRIME_EN defined: PRIME behaves as in REQ-008. Not defined: PRIME SHALL be skipped, grants go directly to STREAM, and tuser[1] SHALL be constant 0.

Structure
REQ-019 Package demod_pkg SHALL hold the state enum sched_state_t, CH_NONE, and localparams ANGLE_MSB=31 and ANGLE_LSB=16.
REQ-020 Round-robin selection SHALL be a sub-module rr_arb2 (req[1:0], last_grant in; gnt[1:0], gnt_id out; combinational).

Verification
REQ-021 Reset release, ch0 sends 3-beat packet angles 0x1000,0x2000,0x3000 with tready=1 -> prime beat tdata=0x00000000 tuser=2'b10, then 3 beats tuser=2'b00 with tlast on the third.
REQ-022 Both channels valid from IDLE -> ch0 packet, bubble cycle, prime beat with tuser=2'b11 and ch1's saved angle, then ch1 packet, then ch0 again (alternation).
REQ-023 ch0 sends two consecutive packets, ch1 idle -> no prime beat before the second packet, and the first beat of packet 2 appears 2 cycles after packet 1's tlast beat.
REQ-024 m00_axis_tready toggles 1,0,0,1 during a packet -> no beat lost or duplicated, and tready follows REQ-009 every cycle.
REQ-025 Reset pulses after beat 2 of a 4-beat packet -> outputs 0 immediately (asynchronous), saved_angle=0, next grant primes with 0x00000000.
REQ-026 Build without DEMOD_SCHED_PRIME_EN, repeat REQ-022 -> no prime beats, tuser[1]=0 throughout.
